// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_pkg                                                            |
// | Opcodes, FSM states and control encodings for the multicycle core.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [2:0] F3_BEQ    = 3'b000;

    localparam logic [1:0] ALU_A_PC    = 2'b00;
    localparam logic [1:0] ALU_A_REG   = 2'b01;
    localparam logic [1:0] ALU_A_OLDPC = 2'b10;

    localparam logic [1:0] ALU_B_REG  = 2'b00;
    localparam logic [1:0] ALU_B_FOUR = 2'b01;
    localparam logic [1:0] ALU_B_IMM  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9
    } state_t;

    // Moore part of the control word; input-dependent strobes live in the top.
    typedef struct packed {
        logic       pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_a = ALU_A_PC;
                c.alu_src_b = ALU_B_FOUR;
                c.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                c.alu_src_a = ALU_A_OLDPC;
                c.alu_src_b = ALU_B_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = ALU_A_REG;
                c.alu_src_b = ALU_B_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = ALU_A_REG;
                c.alu_src_b = ALU_B_REG;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = ALU_A_REG;
                c.alu_src_b = ALU_B_REG;
                c.alu_op    = ALUOP_SUB;
                c.pc_source = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/unidade_controle_multiciclo_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | unidade_controle_multiciclo_if                                       |
// | Decode inputs and control outputs between controller and datapath.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface unidade_controle_multiciclo_if #(
    parameter int W_CNT = 32
);
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             zero;
    logic             mem_ready;
    logic             pc_en;
    logic             pc_source;
    logic             ir_write;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             illegal;
    logic             instr_done;
    logic [W_CNT-1:0] instret;

    modport master (
        input  opcode, funct3, zero, mem_ready,
        output pc_en, pc_source, ir_write, i_or_d, mem_read, mem_write,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               illegal, instr_done, instret
    );

    modport slave (
        output opcode, funct3, zero, mem_ready,
        input  pc_en, pc_source, ir_write, i_or_d, mem_read, mem_write,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               illegal, instr_done, instret
    );
endinterface
`default_nettype wire

// File: rtl/unidade_controle_multiciclo_contador_instret.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | contador_instret                                                     |
// | Wrapping retired-instruction counter with increment enable.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module contador_instret #(
    parameter int W_CNT = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_en,
    output logic      [W_CNT-1:0] o_count
);
    logic [W_CNT-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (i_en)
            r_count <= r_count + W_CNT'(1);
    end

    assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/unidade_controle_multiciclo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | unidade_controle_multiciclo                                          |
// | Multicycle control FSM for lw/sw/beq/R-type on a shared datapath.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module unidade_controle_multiciclo
    import riscv_pkg::*;
#(
    parameter int W_CNT = 32
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    unidade_controle_multiciclo_if.master bus
);
    state_t           r_state;
    state_t           w_next;
    ctrl_t            r_ctrl;
    logic             w_is_load;
    logic             w_is_store;
    logic             w_is_rtype;
    logic             w_is_beq;
    logic             w_legal;
    logic             w_done;
    logic [W_CNT-1:0] w_count;

    assign w_is_load  = (bus.opcode == OP_LOAD);
    assign w_is_store = (bus.opcode == OP_STORE);
    assign w_is_rtype = (bus.opcode == OP_RTYPE);
    assign w_is_beq   = (bus.opcode == OP_BRANCH) && (bus.funct3 == F3_BEQ);
    assign w_legal    = w_is_load || w_is_store || w_is_rtype || w_is_beq;

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:      w_next = S_FETCH;
            S_FETCH:     w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (w_is_load || w_is_store) w_next = S_MEM_ADDR;
                else if (w_is_rtype)         w_next = S_EXECUTE;
                else if (w_is_beq)           w_next = S_BRANCH;
                else                         w_next = S_FETCH;
            end
            S_MEM_ADDR:  w_next = w_is_store ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  w_next = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    w_next = S_FETCH;
            S_MEM_WRITE: w_next = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   w_next = S_ALU_WB;
            S_ALU_WB:    w_next = S_FETCH;
            S_BRANCH:    w_next = S_FETCH;
            default:     w_next = S_IDLE;
        endcase
    end

    // Control word is registered alongside the state so it is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_of(w_next);
        end
    end

    assign w_done = (r_state == S_MEM_WB) || (r_state == S_ALU_WB) ||
                    (r_state == S_BRANCH) ||
                    ((r_state == S_MEM_WRITE) && bus.mem_ready);

    assign bus.pc_en      = ((r_state == S_FETCH) && bus.mem_ready) ||
                            ((r_state == S_BRANCH) && bus.zero);
    assign bus.ir_write   = (r_state == S_FETCH) && bus.mem_ready;
    assign bus.illegal    = (r_state == S_DECODE) && !w_legal;
    assign bus.instr_done = w_done;
    assign bus.pc_source  = r_ctrl.pc_source;
    assign bus.i_or_d     = r_ctrl.i_or_d;
    assign bus.mem_read   = r_ctrl.mem_read;
    assign bus.mem_write  = r_ctrl.mem_write;
    assign bus.reg_write  = r_ctrl.reg_write;
    assign bus.mem_to_reg = r_ctrl.mem_to_reg;
    assign bus.alu_src_a  = r_ctrl.alu_src_a;
    assign bus.alu_src_b  = r_ctrl.alu_src_b;
    assign bus.alu_op     = r_ctrl.alu_op;
    assign bus.instret    = w_count;

    contador_instret #(
        .W_CNT (W_CNT)
    ) u_instret (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_done),
        .o_count (w_count)
    );
endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_multiciclo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_unidade_controle_multiciclo                                       |
// | Table + random instruction stream against an instruction-level model.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_unidade_controle_multiciclo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    unidade_controle_multiciclo_if #(.W_CNT(32)) bus ();
    unidade_controle_multiciclo_if #(.W_CNT(2))  bus2 ();

    assign bus2.opcode    = bus.opcode;
    assign bus2.funct3    = bus.funct3;
    assign bus2.zero      = bus.zero;
    assign bus2.mem_ready = bus.mem_ready;

    unidade_controle_multiciclo #(.W_CNT(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    // Narrow counter instance so the wrap to zero is reachable in a short run.
    unidade_controle_multiciclo #(.W_CNT(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct packed {
        logic       pc_en, pc_source, ir_write, i_or_d;
        logic       mem_read, mem_write, reg_write, mem_to_reg;
        logic [1:0] src_a, src_b, alu_op;
        logic       illegal, instr_done;
    } obs_t;

    typedef struct {
        obs_t exp;
        logic rdy;
    } step_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       z;
        int         fw, mw;
        int         ret, ill, n_mw, n_rw;
    } vec_t;

    step_t       q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cnt  = 0;
    int          obs_ret, obs_ill, obs_mw, obs_rw;

    function automatic obs_t sample();
        obs_t o;
        o.pc_en = bus.pc_en;        o.pc_source = bus.pc_source;
        o.ir_write = bus.ir_write;  o.i_or_d = bus.i_or_d;
        o.mem_read = bus.mem_read;  o.mem_write = bus.mem_write;
        o.reg_write = bus.reg_write; o.mem_to_reg = bus.mem_to_reg;
        o.src_a = bus.alu_src_a;    o.src_b = bus.alu_src_b;
        o.alu_op = bus.alu_op;      o.illegal = bus.illegal;
        o.instr_done = bus.instr_done;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t e);
        obs_t g;
        g = sample();
        n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, g, e);
        end
    endtask

    task automatic check_int(input string name, input logic [31:0] got, input logic [31:0] e);
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, e);
        end
    endtask

    task automatic check_cnt();
        check_int("instret", bus.instret, exp_cnt);
        check_int("instret_w2", {30'd0, bus2.instret}, {30'd0, exp_cnt[1:0]});
    endtask

    // Expected control per phase of an instruction, straight from the port table.
    function automatic obs_t ph_fetch(input logic r);
        obs_t o = '0; o.mem_read = 1; o.src_b = 2'b01; o.pc_en = r; o.ir_write = r; return o;
    endfunction
    function automatic obs_t ph_decode(input logic ill);
        obs_t o = '0; o.src_a = 2'b10; o.src_b = 2'b10; o.illegal = ill; return o;
    endfunction
    function automatic obs_t ph_addr();
        obs_t o = '0; o.src_a = 2'b01; o.src_b = 2'b10; return o;
    endfunction
    function automatic obs_t ph_mread();
        obs_t o = '0; o.mem_read = 1; o.i_or_d = 1; return o;
    endfunction
    function automatic obs_t ph_mwb();
        obs_t o = '0; o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1; return o;
    endfunction
    function automatic obs_t ph_mwrite(input logic r);
        obs_t o = '0; o.mem_write = 1; o.i_or_d = 1; o.instr_done = r; return o;
    endfunction
    function automatic obs_t ph_exec();
        obs_t o = '0; o.src_a = 2'b01; o.alu_op = 2'b10; return o;
    endfunction
    function automatic obs_t ph_awb();
        obs_t o = '0; o.reg_write = 1; o.instr_done = 1; return o;
    endfunction
    function automatic obs_t ph_branch(input logic z);
        obs_t o = '0; o.src_a = 2'b01; o.alu_op = 2'b01; o.pc_source = 1;
        o.pc_en = z; o.instr_done = 1; return o;
    endfunction

    function automatic void push(input obs_t e, input logic r);
        step_t s;
        s.exp = e;
        s.rdy = r;
        q.push_back(s);
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void build(input logic [6:0] op, input logic [2:0] f3,
                                  input logic z, input int fw, input int mw);
        logic lw, sw, rt, bq;
        lw = (op == 7'b0000011);
        sw = (op == 7'b0100011);
        rt = (op == 7'b0110011);
        bq = (op == 7'b1100011) && (f3 == 3'b000);
        q.delete();
        for (int i = 0; i < fw; i++) push(ph_fetch(1'b0), 1'b0);
        push(ph_fetch(1'b1), 1'b1);
        push(ph_decode(!(lw || sw || rt || bq)), rnd());
        if (lw) begin
            push(ph_addr(), rnd());
            for (int i = 0; i < mw; i++) push(ph_mread(), 1'b0);
            push(ph_mread(), 1'b1);
            push(ph_mwb(), rnd());
        end else if (sw) begin
            push(ph_addr(), rnd());
            for (int i = 0; i < mw; i++) push(ph_mwrite(1'b0), 1'b0);
            push(ph_mwrite(1'b1), 1'b1);
        end else if (rt) begin
            push(ph_exec(), rnd());
            push(ph_awb(), rnd());
        end else if (bq) begin
            push(ph_branch(z), rnd());
        end
    endfunction

    // Entered at a negedge with the DUT about to enter FETCH on the next edge.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic z, input int fw, input int mw);
        build(op, f3, z, fw, mw);
        obs_ret = 0; obs_ill = 0; obs_mw = 0; obs_rw = 0;
        foreach (q[i]) begin
            @(posedge clk); #1;
            if (i == 0) begin
                bus.opcode = op; bus.funct3 = f3; bus.zero = z;
            end
            bus.mem_ready = q[i].rdy;
            @(negedge clk);
            check_obs("ctrl", q[i].exp);
            check_cnt();
            obs_ret += int'(bus.instr_done);
            obs_ill += int'(bus.illegal);
            obs_mw  += int'(bus.mem_write);
            obs_rw  += int'(bus.reg_write);
            if (bus.mem_read && bus.mem_write) begin
                n_fail++;
                $display("FAIL rd_wr_excl t=%0t got=both exp=one", $time);
            end
            if (q[i].exp.instr_done) exp_cnt++;
        end
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_obs("idle", '0);
        check_cnt();
    endtask

    vec_t tbl[10];

    initial begin
        bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;

        tbl[0] = '{7'b0000011, 3'b010, 1'b0, 0, 0, 1, 0, 0, 1};
        tbl[1] = '{7'b0100011, 3'b010, 1'b0, 0, 3, 1, 0, 4, 0};
        tbl[2] = '{7'b1100011, 3'b000, 1'b1, 0, 0, 1, 0, 0, 0};
        tbl[3] = '{7'b1100011, 3'b000, 1'b0, 0, 0, 1, 0, 0, 0};
        tbl[4] = '{7'b0010011, 3'b000, 1'b0, 0, 0, 0, 1, 0, 0};
        tbl[5] = '{7'b1100011, 3'b001, 1'b1, 0, 0, 0, 1, 0, 0};
        tbl[6] = '{7'b0110011, 3'b000, 1'b0, 0, 0, 1, 0, 0, 1};
        tbl[7] = '{7'b0000011, 3'b010, 1'b1, 2, 2, 1, 0, 0, 1};
        tbl[8] = '{7'b0100011, 3'b010, 1'b1, 1, 0, 1, 0, 1, 0};
        tbl[9] = '{7'b0110011, 3'b111, 1'b1, 3, 0, 1, 0, 0, 1};

        // Held in reset with mem_ready high: everything must stay quiet.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_obs("in_reset", '0);
            check_cnt();
        end
        release_reset();

        for (int i = 0; i < 10; i++) begin
            run_instr(tbl[i].op, tbl[i].f3, tbl[i].z, tbl[i].fw, tbl[i].mw);
            check_int("tbl_retired", obs_ret, tbl[i].ret);
            check_int("tbl_illegal", obs_ill, tbl[i].ill);
            check_int("tbl_memwrite_cycles", obs_mw, tbl[i].n_mw);
            check_int("tbl_regwrite_cycles", obs_rw, tbl[i].n_rw);
        end

        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            case ($urandom_range(0, 5))
                0: op = 7'b0000011;
                1: op = 7'b0100011;
                2: op = 7'b0110011;
                3: op = 7'b1100011;
                default: op = 7'($urandom);
            endcase
            f3 = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            run_instr(op, f3, rnd(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Asynchronous reset while a load waits on memory.
        @(posedge clk); #1;
        bus.opcode = 7'b0000011; bus.funct3 = 3'b010; bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_obs("mid_read_before", ph_mread());
        #2 rst_n = 1'b0;
        #1;
        check_obs("mid_read_reset", '0);
        exp_cnt = 0;
        check_cnt();
        @(negedge clk);
        check_obs("reset_hold", '0);
        bus.mem_ready = 1'b1;
        release_reset();
        run_instr(7'b0110011, 3'b000, 1'b0, 0, 0);
        run_instr(7'b1100011, 3'b000, 1'b1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
